// File: rtl/bp_cce_mshr_bank.sv
// +--------------------------------------------------------------------------+
// | bp_cce_mshr_bank: multi-entry MSHR store with block-conflict gating.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module bp_cce_mshr_bank #(
  parameter int mshr_els_p               = 4,
  parameter int paddr_width_p            = 40,
  parameter int lce_id_width_p           = 2,
  parameter int lce_assoc_width_p        = 3,
  parameter int flag_width_p             = 16,
  parameter int lg_block_size_in_bytes_p = 6,
  localparam int id_width_lp  = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1,
  localparam int cnt_width_lp = ((mshr_els_p + 1) > 1) ? $clog2(mshr_els_p + 1) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         alloc_v_i,
  output logic                         alloc_ready_and_o,
  input  logic [paddr_width_p-1:0]     alloc_paddr_i,
  input  logic [lce_id_width_p-1:0]    alloc_lce_id_i,
  input  logic [lce_assoc_width_p-1:0] alloc_lru_way_i,
  input  logic [flag_width_p-1:0]      alloc_flags_i,
  output logic [id_width_lp-1:0]       alloc_id_o,
  input  logic                         wr_v_i,
  input  logic [id_width_lp-1:0]       wr_id_i,
  input  logic                         wr_way_v_i,
  input  logic [lce_assoc_width_p-1:0] wr_way_i,
  input  logic                         wr_owner_v_i,
  input  logic [lce_id_width_p-1:0]    wr_owner_i,
  input  logic [flag_width_p-1:0]      wr_flags_mask_i,
  input  logic [flag_width_p-1:0]      wr_flags_i,
  input  logic                         free_v_i,
  input  logic [id_width_lp-1:0]       free_id_i,
  input  logic [id_width_lp-1:0]       rd_id_i,
  output logic                         rd_v_o,
  output logic [paddr_width_p-1:0]     rd_paddr_o,
  output logic [lce_id_width_p-1:0]    rd_lce_id_o,
  output logic [lce_assoc_width_p-1:0] rd_lru_way_o,
  output logic [lce_assoc_width_p-1:0] rd_way_o,
  output logic [lce_id_width_p-1:0]    rd_owner_o,
  output logic [flag_width_p-1:0]      rd_flags_o,
  output logic [cnt_width_lp-1:0]      count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int TAG_MSB = paddr_width_p - 1;
  localparam int TAG_LSB = lg_block_size_in_bytes_p;

  logic [mshr_els_p-1:0]        valid_q, valid_d;
  logic [paddr_width_p-1:0]     paddr_q [mshr_els_p];
  logic [paddr_width_p-1:0]     paddr_d [mshr_els_p];
  logic [lce_id_width_p-1:0]    lce_q   [mshr_els_p];
  logic [lce_id_width_p-1:0]    lce_d   [mshr_els_p];
  logic [lce_assoc_width_p-1:0] lru_q   [mshr_els_p];
  logic [lce_assoc_width_p-1:0] lru_d   [mshr_els_p];
  logic [lce_assoc_width_p-1:0] way_q   [mshr_els_p];
  logic [lce_assoc_width_p-1:0] way_d   [mshr_els_p];
  logic [lce_id_width_p-1:0]    owner_q [mshr_els_p];
  logic [lce_id_width_p-1:0]    owner_d [mshr_els_p];
  logic [flag_width_p-1:0]      flags_q [mshr_els_p];
  logic [flag_width_p-1:0]      flags_d [mshr_els_p];
  logic [cnt_width_lp-1:0]      count_q, count_d;

  logic                   conflict;
  logic                   alloc_fire;
  logic                   free_any;
  logic [id_width_lp-1:0] alloc_id;
  logic [mshr_els_p-1:0]  alloc_sel, free_sel, wr_sel;

  // Descending scan leaves the lowest-index free slot in alloc_id.
  always_comb begin
    conflict = 1'b0;
    alloc_id = '0;
    for (int i = mshr_els_p - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_id = id_width_lp'(i);
      if (valid_q[i] && (paddr_q[i][TAG_MSB:TAG_LSB] == alloc_paddr_i[TAG_MSB:TAG_LSB]))
        conflict = 1'b1;
    end
  end

  assign full_o            = (count_q == cnt_width_lp'(mshr_els_p));
  assign empty_o           = (count_q == '0);
  assign count_o           = count_q;
  assign alloc_ready_and_o = ~full_o & ~conflict;
  assign alloc_id_o        = alloc_id;
  assign alloc_fire        = alloc_v_i & alloc_ready_and_o;

  // Ids beyond the populated depth never match, so they are silently ignored.
  always_comb begin
    for (int i = 0; i < mshr_els_p; i++) begin
      alloc_sel[i] = alloc_fire && (alloc_id == id_width_lp'(i));
      free_sel[i]  = free_v_i && (free_id_i == id_width_lp'(i)) && valid_q[i];
      wr_sel[i]    = wr_v_i && (wr_id_i == id_width_lp'(i)) && valid_q[i];
    end
  end

  assign free_any = |free_sel;

  always_comb begin
    valid_d = valid_q;
    paddr_d = paddr_q;
    lce_d   = lce_q;
    lru_d   = lru_q;
    way_d   = way_q;
    owner_d = owner_q;
    flags_d = flags_q;
    for (int i = 0; i < mshr_els_p; i++) begin
      if (alloc_sel[i]) begin
        valid_d[i] = 1'b1;
        paddr_d[i] = alloc_paddr_i;
        lce_d[i]   = alloc_lce_id_i;
        lru_d[i]   = alloc_lru_way_i;
        way_d[i]   = '0;
        owner_d[i] = '0;
        flags_d[i] = alloc_flags_i;
      end else if (free_sel[i]) begin
        valid_d[i] = 1'b0;
      end else if (wr_sel[i]) begin
        if (wr_way_v_i)   way_d[i]   = wr_way_i;
        if (wr_owner_v_i) owner_d[i] = wr_owner_i;
        flags_d[i] = (flags_q[i] & ~wr_flags_mask_i) | (wr_flags_i & wr_flags_mask_i);
      end
    end
    count_d = count_q + cnt_width_lp'(alloc_fire) - cnt_width_lp'(free_any);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < mshr_els_p; i++) begin
        paddr_q[i] <= '0;
        lce_q[i]   <= '0;
        lru_q[i]   <= '0;
        way_q[i]   <= '0;
        owner_q[i] <= '0;
        flags_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      paddr_q <= paddr_d;
      lce_q   <= lce_d;
      lru_q   <= lru_d;
      way_q   <= way_d;
      owner_q <= owner_d;
      flags_q <= flags_d;
    end
  end

  // Invalid entries read as all zeros rather than exposing stale fields.
  always_comb begin
    rd_v_o       = 1'b0;
    rd_paddr_o   = '0;
    rd_lce_id_o  = '0;
    rd_lru_way_o = '0;
    rd_way_o     = '0;
    rd_owner_o   = '0;
    rd_flags_o   = '0;
    for (int i = 0; i < mshr_els_p; i++) begin
      if ((rd_id_i == id_width_lp'(i)) && valid_q[i]) begin
        rd_v_o       = 1'b1;
        rd_paddr_o   = paddr_q[i];
        rd_lce_id_o  = lce_q[i];
        rd_lru_way_o = lru_q[i];
        rd_way_o     = way_q[i];
        rd_owner_o   = owner_q[i];
        rd_flags_o   = flags_q[i];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && free_v_i && !free_any)
      $error("bp_cce_mshr_bank: free of invalid entry %0d", free_id_i);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_cce_mshr_bank.sv
// Directed-vector bench for bp_cce_mshr_bank; expectations queue up per cycle
// and a negedge monitor compares them against the live DUT outputs.
`default_nettype none

module tb_bp_cce_mshr_bank;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        alloc_v_i;
  logic        alloc_ready_and_o;
  logic [39:0] alloc_paddr_i;
  logic [1:0]  alloc_lce_id_i;
  logic [2:0]  alloc_lru_way_i;
  logic [15:0] alloc_flags_i;
  logic [1:0]  alloc_id_o;
  logic        wr_v_i;
  logic [1:0]  wr_id_i;
  logic        wr_way_v_i;
  logic [2:0]  wr_way_i;
  logic        wr_owner_v_i;
  logic [1:0]  wr_owner_i;
  logic [15:0] wr_flags_mask_i;
  logic [15:0] wr_flags_i;
  logic        free_v_i;
  logic [1:0]  free_id_i;
  logic [1:0]  rd_id_i;
  logic        rd_v_o;
  logic [39:0] rd_paddr_o;
  logic [1:0]  rd_lce_id_o;
  logic [2:0]  rd_lru_way_o;
  logic [2:0]  rd_way_o;
  logic [1:0]  rd_owner_o;
  logic [15:0] rd_flags_o;
  logic [2:0]  count_o;
  logic        full_o;
  logic        empty_o;

  bp_cce_mshr_bank dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_v_i(alloc_v_i), .alloc_ready_and_o(alloc_ready_and_o),
    .alloc_paddr_i(alloc_paddr_i), .alloc_lce_id_i(alloc_lce_id_i),
    .alloc_lru_way_i(alloc_lru_way_i), .alloc_flags_i(alloc_flags_i),
    .alloc_id_o(alloc_id_o),
    .wr_v_i(wr_v_i), .wr_id_i(wr_id_i), .wr_way_v_i(wr_way_v_i), .wr_way_i(wr_way_i),
    .wr_owner_v_i(wr_owner_v_i), .wr_owner_i(wr_owner_i),
    .wr_flags_mask_i(wr_flags_mask_i), .wr_flags_i(wr_flags_i),
    .free_v_i(free_v_i), .free_id_i(free_id_i), .rd_id_i(rd_id_i),
    .rd_v_o(rd_v_o), .rd_paddr_o(rd_paddr_o), .rd_lce_id_o(rd_lce_id_o),
    .rd_lru_way_o(rd_lru_way_o), .rd_way_o(rd_way_o), .rd_owner_o(rd_owner_o),
    .rd_flags_o(rd_flags_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {F_READY, F_AID, F_RDV, F_PADDR, F_LCE, F_LRU, F_WAY, F_OWN,
                    F_FLAGS, F_CNT, F_FULL, F_EMPTY} fld_e;
  typedef struct {
    int          cyc;
    string       name;
    fld_e        f;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t mon_e;
  logic [63:0] mon_a;

  always @(posedge clk_i) cyc++;

  function automatic logic [63:0] act_of(fld_e f);
    case (f)
      F_READY: return 64'(alloc_ready_and_o);
      F_AID:   return 64'(alloc_id_o);
      F_RDV:   return 64'(rd_v_o);
      F_PADDR: return 64'(rd_paddr_o);
      F_LCE:   return 64'(rd_lce_id_o);
      F_LRU:   return 64'(rd_lru_way_o);
      F_WAY:   return 64'(rd_way_o);
      F_OWN:   return 64'(rd_owner_o);
      F_FLAGS: return 64'(rd_flags_o);
      F_CNT:   return 64'(count_o);
      F_FULL:  return 64'(full_o);
      default: return 64'(empty_o);
    endcase
  endfunction

  always @(negedge clk_i) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      mon_a = act_of(mon_e.f);
      n_cmp++;
      if (mon_e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", mon_e.name, mon_e.cyc, cyc);
      end else if (mon_a !== mon_e.exp) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", mon_e.name, cyc, mon_a, mon_e.exp);
      end
    end
  end

  task automatic chk(input string n, input fld_e f, input logic [63:0] v);
    exp_t e;
    e.cyc = cyc; e.name = n; e.f = f; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    alloc_v_i = 0; alloc_paddr_i = '0; alloc_lce_id_i = '0; alloc_lru_way_i = '0; alloc_flags_i = '0;
    wr_v_i = 0; wr_id_i = '0; wr_way_v_i = 0; wr_way_i = '0; wr_owner_v_i = 0; wr_owner_i = '0;
    wr_flags_mask_i = '0; wr_flags_i = '0; free_v_i = 0; free_id_i = '0; rd_id_i = '0;
  endtask

  task automatic alloc(input logic [39:0] pa, input logic [1:0] lce, input logic [2:0] lru,
                       input logic [15:0] fl);
    alloc_v_i = 1; alloc_paddr_i = pa; alloc_lce_id_i = lce; alloc_lru_way_i = lru; alloc_flags_i = fl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    reset_i = 1;
    repeat (3) tick();
    reset_i = 0;
    chk("rst_count", F_CNT, 0); chk("rst_empty", F_EMPTY, 1); chk("rst_full", F_FULL, 0);
    chk("rst_ready", F_READY, 1); chk("rst_rdv", F_RDV, 0);
    tick();

    alloc(40'h1000, 2'd1, 3'd3, 16'h0);
    chk("a0_ready", F_READY, 1); chk("a0_id", F_AID, 0);
    tick();

    idle(); rd_id_i = 0;
    chk("a0_rdv", F_RDV, 1); chk("a0_paddr", F_PADDR, 40'h1000); chk("a0_lce", F_LCE, 1);
    chk("a0_lru", F_LRU, 3); chk("a0_cnt", F_CNT, 1); chk("a0_empty", F_EMPTY, 0);
    alloc(40'h1020, 2'd0, 3'd0, 16'h0);
    chk("conflict_ready", F_READY, 0);
    tick();

    idle(); alloc(40'h1040, 2'd2, 3'd0, 16'h0);
    chk("a1_ready", F_READY, 1); chk("a1_id", F_AID, 1);
    tick();
    idle(); alloc(40'h2000, 2'd0, 3'd0, 16'h0); chk("a2_id", F_AID, 2); tick();
    idle(); alloc(40'h3000, 2'd0, 3'd0, 16'h0); chk("a3_id", F_AID, 3); tick();

    idle(); alloc(40'h5000, 2'd0, 3'd0, 16'h0); free_v_i = 1; free_id_i = 2;
    chk("full_full", F_FULL, 1); chk("full_cnt", F_CNT, 4); chk("full_ready", F_READY, 0);
    tick();

    idle(); alloc(40'h5000, 2'd0, 3'd0, 16'h0);
    chk("refill_ready", F_READY, 1); chk("refill_id", F_AID, 2);
    chk("refill_cnt", F_CNT, 3); chk("refill_full", F_FULL, 0);
    tick();

    idle(); rd_id_i = 2;
    chk("refill_cnt4", F_CNT, 4); chk("refill_full1", F_FULL, 1);
    chk("refill_rdv", F_RDV, 1); chk("refill_paddr", F_PADDR, 40'h5000);
    wr_v_i = 1; wr_id_i = 0; wr_flags_mask_i = 16'h0005; wr_flags_i = 16'hFFFF;
    tick();

    idle(); rd_id_i = 0;
    chk("mask_flags", F_FLAGS, 16'h0005);
    wr_v_i = 1; wr_id_i = 0; wr_way_v_i = 1; wr_way_i = 3'd5;
    tick();

    idle(); rd_id_i = 0;
    chk("way_way", F_WAY, 5); chk("way_owner", F_OWN, 0); chk("way_flags", F_FLAGS, 16'h0005);
    wr_v_i = 1; wr_id_i = 0; wr_owner_v_i = 1; wr_owner_i = 2'd3; wr_flags_i = 16'hFFFF;
    tick();

    idle(); rd_id_i = 0;
    chk("own_owner", F_OWN, 3); chk("own_flags", F_FLAGS, 16'h0005); chk("own_way", F_WAY, 5);
    free_v_i = 1; free_id_i = 1;
    wr_v_i = 1; wr_id_i = 1; wr_way_v_i = 1; wr_way_i = 3'd7; wr_owner_v_i = 1; wr_owner_i = 2'd1;
    wr_flags_mask_i = 16'hFFFF; wr_flags_i = 16'hFFFF;
    tick();

    idle(); rd_id_i = 1;
    chk("fw_rdv", F_RDV, 0); chk("fw_paddr", F_PADDR, 0); chk("fw_way", F_WAY, 0); chk("fw_cnt", F_CNT, 3);
    wr_v_i = 1; wr_id_i = 1; wr_way_v_i = 1; wr_way_i = 3'd6;
    tick();

    idle(); rd_id_i = 1;
    chk("wrinv_rdv", F_RDV, 0); chk("wrinv_cnt", F_CNT, 3);
    alloc(40'h6000, 2'd0, 3'd1, 16'h00A0); free_v_i = 1; free_id_i = 3;
    chk("af_ready", F_READY, 1); chk("af_id", F_AID, 1);
    tick();

    idle(); rd_id_i = 1;
    chk("af_rdv", F_RDV, 1); chk("af_paddr", F_PADDR, 40'h6000); chk("af_way", F_WAY, 0);
    chk("af_owner", F_OWN, 0); chk("af_flags", F_FLAGS, 16'h00A0); chk("af_lru", F_LRU, 1);
    chk("af_cnt", F_CNT, 3);
    tick();
    idle(); rd_id_i = 3; chk("af_freed_rdv", F_RDV, 0); tick();

    idle(); reset_i = 1;
    tick();
    reset_i = 0;
    chk("mrst_cnt", F_CNT, 0); chk("mrst_empty", F_EMPTY, 1); chk("mrst_full", F_FULL, 0);
    for (int i = 0; i < 4; i++) begin
      rd_id_i = 2'(i);
      chk($sformatf("mrst_rdv%0d", i), F_RDV, 0);
      tick();
    end

    idle(); alloc(40'h7000, 2'd2, 3'd2, 16'h0);
    chk("post_ready", F_READY, 1); chk("post_id", F_AID, 0);
    tick();
    idle(); chk("post_cnt", F_CNT, 1);
    tick();
    tick();

    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
